// File: rtl/scan_driver.sv
// Time-multiplexed 7-segment scanner: steps digit positions at a fixed rate,
// with per-slot dead-time blanking, frame snapshotting and masked blinking.
module scan_driver #(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 5000,
  parameter int unsigned BLINK_FRAMES = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [3:0]              bcd_pos,
  output logic [3:0]              bcd_digit,
  output logic                    digit_blank,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DW    = 4 * NUM_DIGITS;
  localparam int unsigned POS_W = 3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [FR_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [DW-1:0]    snap_q, snap_d;

  logic [3:0]       bcd_pos_q, bcd_pos_d;
  logic [3:0]       bcd_digit_q, bcd_digit_d;
  logic             digit_blank_q, digit_blank_d;
  logic             frame_tick_q, frame_tick_d;

  logic             slot_end;
  logic             wrap;
  logic             vis;
  logic [7:0]       mask_pad;
  logic [31:0]      snap_pad;
  logic [3:0]       nibble;

  // Slot/frame counters, snapshot and blink phase
  always_comb begin
    cnt_d         = cnt_q;
    pos_d         = pos_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    snap_d        = snap_q;

    slot_end = (cnt_q == CNT_W'(SCAN_DIV - 1));
    wrap     = en && slot_end && (pos_q == POS_W'(NUM_DIGITS - 1));

    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        pos_d = wrap ? '0 : pos_q + POS_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (wrap) begin
      snap_d = digits;
      if (frame_cnt_q == FR_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FR_W'(1);
      end
    end
  end

  // Output selection from the current state; registered below
  always_comb begin
    mask_pad = 8'(blink_mask);
    snap_pad = 32'(snap_q);
    nibble   = 4'h0;
    for (int i = 0; i < 8; i++) begin
      if (pos_q == POS_W'(i)) nibble = snap_pad[i*4 +: 4];
    end

    vis = en && (cnt_q >= CNT_W'(BLANK_CYCLES)) && !(blink_phase_q && mask_pad[pos_q]);

    bcd_pos_d     = 4'hF;
    bcd_digit_d   = 4'h0;
    digit_blank_d = 1'b1;
    frame_tick_d  = wrap;
    if (vis) begin
      bcd_pos_d     = 4'(pos_q);
      bcd_digit_d   = nibble;
      digit_blank_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      pos_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_q        <= '0;
      bcd_pos_q     <= 4'hF;
      bcd_digit_q   <= 4'h0;
      digit_blank_q <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pos_q         <= pos_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      bcd_pos_q     <= bcd_pos_d;
      bcd_digit_q   <= bcd_digit_d;
      digit_blank_q <= digit_blank_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign bcd_pos     = bcd_pos_q;
  assign bcd_digit   = bcd_digit_q;
  assign digit_blank = digit_blank_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_scan_driver.sv
// Randomized bench for scan_driver against a model that derives slot, position,
// frame and blink phase arithmetically from the count of enabled cycles.
module tb_scan_driver;

  localparam int ND = 6;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [4*ND-1:0] digits = '0;
  logic [ND-1:0] blink_mask = '0;
  logic [3:0]    bcd_pos;
  logic [3:0]    bcd_digit;
  logic          digit_blank;
  logic          frame_tick;

  int errors = 0;
  int checks = 0;

  // Model state: enabled cycles since reset and the frame snapshot
  int            n = 0;
  logic [4*ND-1:0] snap = '0;
  int            ticks_seen = 0;
  int            ticks_exp = 0;

  scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .blink_mask(blink_mask),
    .bcd_pos(bcd_pos), .bcd_digit(bcd_digit), .digit_blank(digit_blank),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (n=%0d t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  // One clock: predict outputs from the pre-edge model state and inputs, then compare.
  task automatic step();
    int cnt, pos, frame, phase;
    logic vis, tick;
    logic [3:0] e_pos, e_dig;
    cnt   = n % SD;
    pos   = (n / SD) % ND;
    frame = n / (SD * ND);
    phase = (frame / BF) % 2;
    vis   = en && (cnt >= BC) && !((phase == 1) && blink_mask[pos]);
    tick  = en && (cnt == SD - 1) && (pos == ND - 1);
    e_pos = vis ? 4'(pos) : 4'hF;
    e_dig = vis ? 4'((snap >> (4 * pos)) & 24'hF) : 4'h0;
    if (en) begin
      if (tick) snap = digits;
      n++;
    end
    if (tick) ticks_exp++;
    @(posedge clk);
    #1;
    if (frame_tick) ticks_seen++;
    check("bcd_pos", 32'(bcd_pos), 32'(e_pos));
    check("bcd_digit", 32'(bcd_digit), 32'(e_dig));
    check("digit_blank", 32'(digit_blank), 32'(!vis));
    check("frame_tick", 32'(frame_tick), 32'(tick));
  endtask

  // Asynchronous reset pulse between clock edges; outputs must blank immediately.
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_pos", 32'(bcd_pos), 32'hF);
    check("rst_blank", 32'(digit_blank), 32'h1);
    check("rst_digit", 32'(bcd_digit), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    n = 0;
    snap = '0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("init_pos", 32'(bcd_pos), 32'hF);
    check("init_blank", 32'(digit_blank), 32'h1);
    rst_n = 1'b1;

    // Run to cnt=5 of pos 3, then reset mid-slot
    digits = 24'h123456;
    en = 1'b1;
    repeat (29) step();
    async_reset();

    // Free-running scan: zeros in frame 0, then 6,5,4,3,2,1; digits change mid frame 1
    for (int c = 0; c < 48 * 5; c++) begin
      if (c == 48 + 2 * SD) digits = 24'h999999;
      if (c == 48 * 2) blink_mask = 6'b000011;
      step();
    end
    check("tick_count_free", 32'(ticks_seen), 32'(ticks_exp));
    check("tick_count_abs", 32'(ticks_seen), 32'd5);

    // Pause at cnt=4 of pos 2 for 10 cycles
    while ((n % SD) != 4 || ((n / SD) % ND) != 2) step();
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    repeat (SD) step();

    // Randomized phase: enable gaps, digit/mask changes, occasional async resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) digits = 24'($urandom);
      if ($urandom_range(0, 99) == 0) blink_mask = 6'($urandom);
      step();
    end
    check("tick_count_rand", 32'(ticks_seen), 32'(ticks_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
